keypoint_scan_ctrl: RTL and testbench

Parametrised raster-scan controller for DoG extremum detection and filtering over NUM_SCALES scale triplets.
- Sequences row fetches from the pyramid SRAMs and shifts the line buffers.
- Walks each interior column, qualifies candidates with the external filter flags, and writes {row,col} to one keypoint SRAM per scale.
- Keeps saturating per-scale counts and sticky overflow flags.
- Sits between the blur/DoG SRAMs and the orientation stage; detect/filter comparators stay external and combinational.

---
 rtl/keypoint_scan_if.sv | 41 ++++
 rtl/keypoint_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_keypoint_scan_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypoint_scan_if.sv
// Bundle between the keypoint scan controller and its pyramid SRAMs, comparators and keypoint SRAMs.
// cand_count is present only when KP_CANDIDATE_COUNT_EN is defined.
interface keypoint_scan_if #(
  parameter int ROW_W      = 9,
  parameter int COL_W      = 10,
  parameter int NUM_SCALES = 2,
  parameter int KP_ADDR_W  = 11
);
  logic                                start;
  logic                                busy;
  logic                                done;
  logic [ROW_W-1:0]                    row_addr;
  logic                                buffer_we;
  logic [COL_W-1:0]                    col;
  logic [NUM_SCALES-1:0]               is_kp;
  logic [NUM_SCALES-1:0]               valid_kp;
  logic [NUM_SCALES-1:0]               kp_we;
  logic [NUM_SCALES*KP_ADDR_W-1:0]     kp_addr;
  logic [ROW_W+COL_W-1:0]              kp_din;
  logic [NUM_SCALES*(KP_ADDR_W+1)-1:0] kp_count;
  logic [NUM_SCALES-1:0]               kp_ovf;
`ifdef KP_CANDIDATE_COUNT_EN
  logic [NUM_SCALES*(ROW_W+COL_W)-1:0] cand_count;
`endif

  modport master (
    input  start, is_kp, valid_kp,
    output busy, done, row_addr, buffer_we, col, kp_we, kp_addr, kp_din, kp_count, kp_ovf
`ifdef KP_CANDIDATE_COUNT_EN
    , output cand_count
`endif
  );

  modport slave (
    output start, is_kp, valid_kp,
    input  busy, done, row_addr, buffer_we, col, kp_we, kp_addr, kp_din, kp_count, kp_ovf
`ifdef KP_CANDIDATE_COUNT_EN
    , input cand_count
`endif
  );
endinterface

// File: rtl/keypoint_scan_ctrl.sv
// Raster-scan controller for DoG extremum detection: row fetch, column walk, per-scale keypoint writes.
// Optional KP_CANDIDATE_COUNT_EN adds per-scale raw candidate counters (cand_count).
module kp_scale_slot #(
  parameter int KP_ADDR_W = 11
`ifdef KP_CANDIDATE_COUNT_EN
  , parameter int CAND_W  = 19
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 filt,
  input  logic                 hit,
  input  logic                 pass,
  output logic                 we,
  output logic                 we_nxt,
  output logic [KP_ADDR_W-1:0] addr,
  output logic [KP_ADDR_W:0]   count,
  output logic                 ovf
`ifdef KP_CANDIDATE_COUNT_EN
  , output logic [CAND_W-1:0]  cand
`endif
);
  localparam logic [KP_ADDR_W:0] CAP = {1'b1, {KP_ADDR_W{1'b0}}};

  logic                 we_q, we_d;
  logic [KP_ADDR_W-1:0] addr_q, addr_d;
  logic [KP_ADDR_W:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;

  // FILTER cycles are never back to back, so count_q already reflects the previous write here.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      addr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (we_q) begin
        addr_d  = addr_q + KP_ADDR_W'(1);
        count_d = count_q + (KP_ADDR_W+1)'(1);
      end
      if (filt && hit && pass) begin
        if (count_q < CAP) we_d = 1'b1;
        else               ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign we     = we_q;
  assign we_nxt = we_d;
  assign addr   = addr_q;
  assign count  = count_q;
  assign ovf    = ovf_q;

`ifdef KP_CANDIDATE_COUNT_EN
  logic [CAND_W-1:0] cand_q, cand_d;

  always_comb begin
    cand_d = cand_q;
    if (clr)                                   cand_d = '0;
    else if (filt && hit && (cand_q != '1))    cand_d = cand_q + CAND_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cand_q <= '0;
    else        cand_q <= cand_d;
  end

  assign cand = cand_q;
`endif
endmodule

module keypoint_scan_ctrl #(
  parameter int ROWS       = 480,
  parameter int COLS       = 640,
  parameter int NUM_SCALES = 2,
  parameter int KP_ADDR_W  = 11,
  parameter int ROW_W      = $clog2(ROWS),
  parameter int COL_W      = $clog2(COLS)
) (
  input logic            clk,
  input logic            rst_n,
  keypoint_scan_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_SCAN, S_FILTER, S_UPDATE, S_WAIT, S_DONE
  } state_e;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 2);

  state_e                 state_q, state_d;
  logic [ROW_W-1:0]       row_addr_q, row_addr_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [1:0]             prime_cnt_q, prime_cnt_d;
  logic [ROW_W+COL_W-1:0] kp_din_q, kp_din_d;
  logic                   clr, filt, busy, done, buffer_we;

  logic [NUM_SCALES-1:0]                 kp_we, kp_we_nxt, kp_ovf;
  logic [NUM_SCALES-1:0][KP_ADDR_W-1:0]  kp_addr;
  logic [NUM_SCALES-1:0][KP_ADDR_W:0]    kp_count;
`ifdef KP_CANDIDATE_COUNT_EN
  logic [NUM_SCALES-1:0][ROW_W+COL_W-1:0] cand_count;
`endif

  always_comb begin
    state_d     = state_q;
    row_addr_d  = row_addr_q;
    col_d       = col_q;
    prime_cnt_d = prime_cnt_q;
    clr         = 1'b0;
    filt        = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    buffer_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          clr         = 1'b1;
          row_addr_d  = '0;
          col_d       = COL_W'(1);
          prime_cnt_d = '0;
          state_d     = S_PRIME;
        end
      end
      // Rows 0 and 1 land in the line buffers; row 2 is read straight from SRAM during SCAN.
      S_PRIME: begin
        buffer_we   = (prime_cnt_q != 2'd0);
        prime_cnt_d = prime_cnt_q + 2'd1;
        if (prime_cnt_q == 2'd2) begin
          prime_cnt_d = '0;
          state_d     = S_SCAN;
        end else begin
          row_addr_d = row_addr_q + ROW_W'(1);
        end
      end
      S_SCAN: begin
        if (|bus.is_kp)             state_d = S_FILTER;
        else if (col_q == LAST_COL) state_d = S_UPDATE;
        else                        col_d   = col_q + COL_W'(1);
      end
      S_FILTER: begin
        filt = 1'b1;
        if (col_q == LAST_COL) begin
          state_d = S_UPDATE;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_SCAN;
        end
      end
      S_UPDATE: begin
        buffer_we = 1'b1;
        col_d     = COL_W'(1);
        if (row_addr_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          row_addr_d = row_addr_q + ROW_W'(1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT:  state_d = S_SCAN;
      S_DONE: begin
        done       = 1'b1;
        row_addr_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    kp_din_d = (|kp_we_nxt) ? {row_addr_q - ROW_W'(1), col_q} : kp_din_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_addr_q  <= '0;
      col_q       <= COL_W'(1);
      prime_cnt_q <= '0;
      kp_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_addr_q  <= row_addr_d;
      col_q       <= col_d;
      prime_cnt_q <= prime_cnt_d;
      kp_din_q    <= kp_din_d;
    end
  end

  for (genvar s = 0; s < NUM_SCALES; s++) begin : g_scale
    kp_scale_slot #(
      .KP_ADDR_W (KP_ADDR_W)
`ifdef KP_CANDIDATE_COUNT_EN
      , .CAND_W  (ROW_W + COL_W)
`endif
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .filt   (filt),
      .hit    (bus.is_kp[s]),
      .pass   (bus.valid_kp[s]),
      .we     (kp_we[s]),
      .we_nxt (kp_we_nxt[s]),
      .addr   (kp_addr[s]),
      .count  (kp_count[s]),
      .ovf    (kp_ovf[s])
`ifdef KP_CANDIDATE_COUNT_EN
      , .cand (cand_count[s])
`endif
    );
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.row_addr  = row_addr_q;
  assign bus.buffer_we = buffer_we;
  assign bus.col       = col_q;
  assign bus.kp_we     = kp_we;
  assign bus.kp_addr   = kp_addr;
  assign bus.kp_din    = kp_din_q;
  assign bus.kp_count  = kp_count;
  assign bus.kp_ovf    = kp_ovf;
`ifdef KP_CANDIDATE_COUNT_EN
  assign bus.cand_count = cand_count;
`endif
endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Directed bench for keypoint_scan_ctrl on a 5x6 frame, two scales, 4-entry keypoint SRAMs.
// Candidate flags come from per-(row,col) tables looked up at (row_addr-1, col).
module tb_keypoint_scan_ctrl;
  localparam int ROWS = 5, COLS = 6, NS = 2, KA = 2;
  localparam int RW = 3, CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypoint_scan_if #(.ROW_W(RW), .COL_W(CW), .NUM_SCALES(NS), .KP_ADDR_W(KA)) bus ();

  keypoint_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .NUM_SCALES(NS), .KP_ADDR_W(KA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [1:0] t_is [0:7][0:7];
  logic [1:0] t_va [0:7][0:7];

  always_comb begin
    int r;
    r = int'(bus.row_addr) - 1;
    bus.is_kp    = '0;
    bus.valid_kp = '0;
    if (r >= 0) begin
      bus.is_kp    = t_is[r][bus.col];
      bus.valid_kp = t_va[r][bus.col];
    end
  end

  int n_cmp = 0, n_err = 0;
  int tr_row [0:63], tr_col [0:63], tr_bwe [0:63], tr_busy [0:63], tr_we [0:63], tr_ovf [0:63];
  int wr_k [0:15], wr_we [0:15], wr_din [0:15], wr_a0 [0:15], wr_a1 [0:15];
  int wr_n;
  int done_k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_tables();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        t_is[r][c] = 2'b00;
        t_va[r][c] = 2'b00;
      end
  endtask

  // Sample k is the cycle k after the start-sampling edge; inputs change right after sampling.
  task automatic run_frame(input int restart_k, input int rst_k, input int max_k, output int dk);
    dk   = 0;
    wr_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      tr_row[k]  = int'(bus.row_addr);
      tr_col[k]  = int'(bus.col);
      tr_bwe[k]  = int'(bus.buffer_we);
      tr_busy[k] = int'(bus.busy);
      tr_we[k]   = int'(bus.kp_we);
      tr_ovf[k]  = int'(bus.kp_ovf);
      if (bus.kp_we != 0 && wr_n < 16) begin
        wr_k[wr_n]   = k;
        wr_we[wr_n]  = int'(bus.kp_we);
        wr_din[wr_n] = int'(bus.kp_din);
        wr_a0[wr_n]  = int'(bus.kp_addr[1:0]);
        wr_a1[wr_n]  = int'(bus.kp_addr[3:2]);
        wr_n++;
      end
      bus.start = (k == restart_k);
      rst_n     = (k != rst_k);
      if (bus.done) begin
        dk = k;
        break;
      end
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    int acc;
    bus.start = 1'b0;
    clear_tables();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_bwe", bus.buffer_we, 0);
    chk("rst_row", bus.row_addr, 0);
    chk("rst_col", bus.col, 1);
    chk("rst_kp_we", bus.kp_we, 0);
    chk("rst_kp_addr", bus.kp_addr, 0);
    chk("rst_kp_count", bus.kp_count, 0);
    chk("rst_kp_ovf", bus.kp_ovf, 0);
    chk("rst_kp_din", bus.kp_din, 0);
    rst_n = 1'b1;

    // Empty frame: PRIME 3, rows 2..4 of COLS cycles each minus the last WAIT, then DONE.
    // done lands 21 cycles after the start edge, i.e. 22 cycles counting the start cycle.
    run_frame(0, 0, 60, done_k);
    chk("t1_done_lat", done_k, 21);
    chk("t1_p1_row", tr_row[1], 0);
    chk("t1_p1_bwe", tr_bwe[1], 0);
    chk("t1_p1_busy", tr_busy[1], 1);
    chk("t1_p2_row", tr_row[2], 1);
    chk("t1_p2_bwe", tr_bwe[2], 1);
    chk("t1_p3_row", tr_row[3], 2);
    chk("t1_p3_bwe", tr_bwe[3], 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("t1_scan_row_%0d_%0d", r, c), tr_row[4 + 6*r + c], 2 + r);
        chk($sformatf("t1_scan_col_%0d_%0d", r, c), tr_col[4 + 6*r + c], 1 + c);
        chk($sformatf("t1_scan_bwe_%0d_%0d", r, c), tr_bwe[4 + 6*r + c], 0);
      end
    chk("t1_upd_bwe", tr_bwe[8], 1);
    chk("t1_wait_row", tr_row[9], 3);
    chk("t1_wait_col", tr_col[9], 1);
    chk("t1_last_upd_bwe", tr_bwe[20], 1);
    chk("t1_last_upd_row", tr_row[20], 4);
    chk("t1_done_busy", tr_busy[21], 1);
    chk("t1_no_writes", wr_n, 0);
    @(negedge clk);
    chk("t1_after_busy", bus.busy, 0);
    chk("t1_after_done", bus.done, 0);
    chk("t1_after_row", bus.row_addr, 0);

    // Scale-0 keypoint at centre (2,3): FILTER at k13, write at k14.
    clear_tables();
    t_is[2][3] = 2'b01; t_va[2][3] = 2'b01;
    run_frame(0, 0, 60, done_k);
    chk("t2_done_lat", done_k, 22);
    chk("t2_filter_col", tr_col[13], 3);
    chk("t2_post_col", tr_col[14], 4);
    chk("t2_wr_n", wr_n, 1);
    chk("t2_wr_k", wr_k[0], 14);
    chk("t2_wr_we", wr_we[0], 2'b01);
    chk("t2_wr_din", wr_din[0], {3'd2, 3'd3});
    chk("t2_wr_a0", wr_a0[0], 0);
    @(negedge clk);
    chk("t2_addr0", bus.kp_addr[1:0], 1);
    chk("t2_addr1", bus.kp_addr[3:2], 0);
    chk("t2_count0", bus.kp_count[2:0], 1);
    chk("t2_count1", bus.kp_count[5:3], 0);
    chk("t2_ovf", bus.kp_ovf, 0);

    // Both scales flag at (1,4), only scale 1 passes; last column so FILTER exits to UPDATE.
    clear_tables();
    t_is[1][4] = 2'b11; t_va[1][4] = 2'b10;
    run_frame(0, 0, 60, done_k);
    chk("t3_done_lat", done_k, 22);
    chk("t3_wr_n", wr_n, 1);
    chk("t3_wr_k", wr_k[0], 9);
    chk("t3_wr_we", wr_we[0], 2'b10);
    chk("t3_wr_din", wr_din[0], {3'd1, 3'd4});
    chk("t3_wr_a1", wr_a1[0], 0);
    chk("t3_upd_bwe", tr_bwe[9], 1);
    chk("t3_wait_row", tr_row[10], 3);
    chk("t3_wait_col", tr_col[10], 1);
    @(negedge clk);
    chk("t3_count0_cleared", bus.kp_count[2:0], 0);
    chk("t3_addr0_cleared", bus.kp_addr[1:0], 0);
    chk("t3_count1", bus.kp_count[5:3], 1);
    chk("t3_addr1", bus.kp_addr[3:2], 1);

    // Five scale-0 hits into a 4-entry SRAM: the fifth sets ovf and writes nothing.
    clear_tables();
    t_is[1][1] = 2'b01; t_va[1][1] = 2'b01;
    t_is[1][3] = 2'b01; t_va[1][3] = 2'b01;
    t_is[2][1] = 2'b01; t_va[2][1] = 2'b01;
    t_is[2][3] = 2'b01; t_va[2][3] = 2'b01;
    t_is[3][2] = 2'b01; t_va[3][2] = 2'b01;
    run_frame(0, 0, 60, done_k);
    chk("t4_done_lat", done_k, 26);
    chk("t4_wr_n", wr_n, 4);
    chk("t4_wr0_k", wr_k[0], 6);
    chk("t4_wr3_k", wr_k[3], 17);
    chk("t4_wr0_din", wr_din[0], {3'd1, 3'd1});
    chk("t4_wr1_din", wr_din[1], {3'd1, 3'd3});
    chk("t4_wr2_din", wr_din[2], {3'd2, 3'd1});
    chk("t4_wr3_din", wr_din[3], {3'd2, 3'd3});
    for (int i = 0; i < 4; i++) chk($sformatf("t4_wr%0d_a0", i), wr_a0[i], i);
    chk("t4_ovf_before", tr_ovf[22], 0);
    chk("t4_ovf_after", tr_ovf[23], 1);
    @(negedge clk);
    chk("t4_count0", bus.kp_count[2:0], 4);
    chk("t4_addr0_wrapped", bus.kp_addr[1:0], 0);
    chk("t4_ovf_end", bus.kp_ovf, 2'b01);

    // Second start during PRIME, then reset in the cycle the (1,2) write is pending.
    clear_tables();
    t_is[1][2] = 2'b01; t_va[1][2] = 2'b01;
    run_frame(2, 7, 12, done_k);
    chk("t5_no_done", done_k, 0);
    chk("t5_p3_row", tr_row[3], 2);
    chk("t5_scan_row", tr_row[4], 2);
    chk("t5_scan_col", tr_col[4], 1);
    chk("t5_pending_we", tr_we[7], 2'b01);
    chk("t5_rst_busy", tr_busy[8], 0);
    chk("t5_rst_row", tr_row[8], 0);
    chk("t5_rst_col", tr_col[8], 1);
    acc = 0;
    for (int k = 8; k <= 12; k++) acc |= tr_we[k];
    chk("t5_no_we_after", acc, 0);
    chk("t5_count", bus.kp_count, 0);
    chk("t5_addr", bus.kp_addr, 0);
    chk("t5_ovf", bus.kp_ovf, 0);
    chk("t5_din", bus.kp_din, 0);

`ifdef KP_CANDIDATE_COUNT_EN
    // Three raw scale-1 candidates, one passing; a following empty frame clears the counters.
    clear_tables();
    t_is[1][1] = 2'b10; t_va[1][1] = 2'b10;
    t_is[2][2] = 2'b10;
    t_is[3][3] = 2'b10;
    run_frame(0, 0, 60, done_k);
    chk("t6_done_lat", done_k, 24);
    @(negedge clk);
    chk("t6_cand1", bus.cand_count[11:6], 3);
    chk("t6_cand0", bus.cand_count[5:0], 0);
    chk("t6_count1", bus.kp_count[5:3], 1);
    clear_tables();
    run_frame(0, 0, 60, done_k);
    @(negedge clk);
    chk("t6_cand1_cleared", bus.cand_count[11:6], 0);
    chk("t6_count1_cleared", bus.kp_count[5:3], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
